fxp_mac: RTL and testbench
==========================

# fxp_mac

Signed fixed-point multiply-accumulate unit: each clock it multiplies two N-bit two's-complement operands and adds the full-precision product into a 2N-bit accumulator register. It is the arithmetic core of a neuron datapath and is built from two submodules, `qmult` (full-precision signed multiplier) and `qadd` (2N-bit signed adder with overflow detect). The accumulator value and an adder-overflow flag are exported to the surrounding datapath.

## Interface

Parameters:
- `Q`, default 0: number of fractional bits in each operand; product and accumulator carry 2Q fractional bits. Legal range 0 ≤ Q < N.
- `N`, default 2: operand width in bits; accumulator/result width is 2N. Minimum N = 2.

Ports:
- `clk`  input  1  single clock; all state updates on its rising edge.
- `reset`  input  1  synchronous, active-high; clears the accumulator on a rising `clk` edge while high.
- `a`  input  N  multiplicand, signed two's complement, Q fractional bits.
- `b`  input  N  multiplier, signed two's complement, Q fractional bits.
- `result`  output  2N  accumulator register contents, signed, 2Q fractional bits.
- `overflow`  output  1  combinational signed-overflow flag of the pending addition `result + a*b`.

## Operation

- `qmult`: combinational; product = sign-extended `a` × sign-extended `b`, 2N bits, 2Q fractional bits. Exact, no rounding or truncation. Its overflow output is tied to 0, because the largest magnitude, (−2^(N−1))², fits in 2N signed bits.
- `qadd`: combinational; sum = accumulator + product, modulo 2^(2N), two's-complement wrap with no saturation.
- `qadd` overflow = (acc[2N−1] == prod[2N−1]) AND (sum[2N−1] != acc[2N−1]).
- `overflow` output = `qadd` overflow. It reflects the addition that will be committed at the next clock edge, not a sticky history.
- Accumulator register: 2N bits. On each rising edge it loads `sum`, or 0 when `reset` = 1.
- `result` = accumulator register, driven directly with no extra logic.
- There is no enable. The unit accumulates `a*b` every cycle that `reset` is low. To hold the value, drive `a` = 0 or `b` = 0.

## Timing

- Reset value: `result` = 0 after the first rising edge with `reset` = 1. `overflow` then equals the overflow of 0 + a*b, which is always 0.
- `reset` is sampled only at rising edges. An asynchronous assertion has no effect until the next edge.
- Reset has priority. With `reset` high, the operands at that edge are discarded.
- After `reset` deasserts, the operands present at the first edge with `reset` low are accumulated. Callers must drive `a`/`b` = 0 during that cycle if a clean zero start is required.
- Latency: operands sampled at edge k appear in `result` after edge k. Throughput is one MAC per cycle.
- Wrap-around: on overflow, the accumulator stores the wrapped sum and continues accumulating from it. `overflow` is high only during the cycle in which the overflowing addition is pending.
- Operand changes between edges affect only `overflow` combinationally, never `result`.

## Test plan

All scenarios use N = 2, Q = 0; the 4-bit accumulator range is −8..7.

1. Reset then accumulate: reset for 1 edge, with a = b = 0 for the first edge after release, then hold a = 01, b = 01 for 2 edges. Required: `result` = 0000, then 0001, then 0010; `overflow` = 0 throughout.
2. Mixed signs and negative×negative: from `result` = 2, apply a = 01, b = 11 for 1 edge, then a = 11, b = 11 for 1 edge. Required: `result` = 0001 (1), then 0010 (2).
3. Reset mid-accumulation with live operands: at `result` = 2, with a = b = 11, assert `reset` for 1 edge. Required: `result` = 0 at that edge. Keeping a = b = 11 at the next edge gives `result` = 1. Then apply a = 01, b = 11 for 1 edge. Required: `result` = 0.
4. Most-negative product: a = b = 10 (−2), from `result` = 0. Required: product = 4, `result` = 0100 after 1 edge, no multiplier overflow.
5. Positive overflow and wrap: from `result` = 4, keep a = b = 10. Required: before the edge, `overflow` = 1 because 4 + 4 wraps. After the edge, `result` = 1000 (−8). With the next sum −8 + 4 = −4, `overflow` = 0.
6. Negative overflow: drive `result` to −8, then a = 01, b = 10 (product −2). Required: `overflow` = 1, and after the edge `result` = 0110 (6).

Source files
------------

// File: rtl/fxp_mac.sv
// Signed fixed-point multiply-accumulate core.
// Each clock the full-precision product a*b is added into a 2N-bit
// accumulator, which wraps on overflow. The overflow flag describes the
// addition that the next rising edge will commit.

// Full-precision signed multiplier: N x N -> 2N bits, exact.
module qmult #(
    parameter int N = 2
) (
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] prod,
    output logic           ovf
);
    logic signed [2*N-1:0] a_ext;
    logic signed [2*N-1:0] b_ext;

    // Sign-extend both operands to 2N bits; the low 2N bits of their
    // product are the exact signed product, since (-2^(N-1))^2 still fits.
    always_comb begin
        a_ext = {{N{a[N-1]}}, a};
        b_ext = {{N{b[N-1]}}, b};
        prod  = a_ext * b_ext;
        ovf   = 1'b0;
    end
endmodule

// 2N-bit two's-complement adder, wraps modulo 2^(2N), flags signed overflow.
module qadd #(
    parameter int N = 2
) (
    input  logic [2*N-1:0] acc,
    input  logic [2*N-1:0] prod,
    output logic [2*N-1:0] sum,
    output logic           ovf
);
    // Overflow when both addends share a sign and the sum's sign differs.
    always_comb begin
        sum = acc + prod;
        ovf = (acc[2*N-1] == prod[2*N-1]) && (sum[2*N-1] != acc[2*N-1]);
    end
endmodule

// Top level: multiplier feeding adder feeding the accumulator register.
module fxp_mac #(
    parameter int Q = 0,
    parameter int N = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] result,
    output logic           overflow
);
    localparam int W = 2 * N;

    // Q only fixes where the binary point sits; the arithmetic is identical
    // for every legal Q, so it is only range-checked here.
    if (Q < 0 || Q >= N || N < 2) begin : g_param_check
        $error("fxp_mac: illegal parameters, need N >= 2 and 0 <= Q < N");
    end

    logic [W-1:0] acc_q;
    logic [W-1:0] acc_d;
    logic [W-1:0] prod;
    logic [W-1:0] sum;
    logic         mult_ovf;
    logic         add_ovf;

    qmult #(.N(N)) u_qmult (
        .a    (a),
        .b    (b),
        .prod (prod),
        .ovf  (mult_ovf)
    );

    qadd #(.N(N)) u_qadd (
        .acc  (acc_q),
        .prod (prod),
        .sum  (sum),
        .ovf  (add_ovf)
    );

    // Next accumulator value is always the wrapped sum; no enable exists,
    // so holding requires a zero operand.
    always_comb begin
        acc_d = sum;
    end

    // Accumulator register; synchronous reset discards the operands at that edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // The multiplier cannot overflow (its flag is constant 0); the OR keeps
    // the structure honest should the multiplier ever become narrowing.
    always_comb begin
        result   = acc_q;
        overflow = add_ovf | mult_ovf;
    end
endmodule

// File: tb/tb_fxp_mac.sv
// Directed self-checking bench for fxp_mac with N = 2, Q = 0.
// Inputs change 1 time unit after a rising edge; result is checked there,
// and overflow is checked combinationally once the new operands settle.
module tb_fxp_mac;
    logic       clk;
    logic       reset;
    logic [1:0] a;
    logic [1:0] b;
    logic [3:0] result;
    logic       overflow;

    int errors;
    int checks;

    fxp_mac #(.Q(0), .N(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .a        (a),
        .b        (b),
        .result   (result),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One clock edge, then settle; prints one line per transaction.
    task automatic tick();
        @(posedge clk);
        #1;
        $display("edge: reset=%b a=%b b=%b -> result=%b overflow=%b",
                 reset, a, b, result, overflow);
    endtask

    // Apply new operands away from the edge and let combinational logic settle.
    task automatic drive(input logic r, input logic [1:0] av, input logic [1:0] bv);
        reset = r;
        a     = av;
        b     = bv;
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        a      = 2'b00;
        b      = 2'b00;

        // Reset state
        tick();
        check("reset_result", result, 4'b0000);
        check("reset_ovf", {3'b000, overflow}, 4'b0000);

        // 1. Clean start then accumulate 1*1 twice
        drive(1'b0, 2'b00, 2'b00);
        tick();
        check("t1_zero_start", result, 4'b0000);
        drive(1'b0, 2'b01, 2'b01);
        check("t1_ovf_a", {3'b000, overflow}, 4'b0000);
        tick();
        check("t1_acc1", result, 4'b0001);
        check("t1_ovf_b", {3'b000, overflow}, 4'b0000);
        tick();
        check("t1_acc2", result, 4'b0010);

        // 2. 2 + 1*(-1) = 1, then 1 + (-1)*(-1) = 2
        drive(1'b0, 2'b01, 2'b11);
        tick();
        check("t2_mixed", result, 4'b0001);
        drive(1'b0, 2'b11, 2'b11);
        tick();
        check("t2_negneg", result, 4'b0010);

        // 3. Reset with live operands, then resume
        drive(1'b1, 2'b11, 2'b11);
        tick();
        check("t3_reset_mid", result, 4'b0000);
        drive(1'b0, 2'b11, 2'b11);
        tick();
        check("t3_after_rst", result, 4'b0001);
        drive(1'b0, 2'b01, 2'b11);
        tick();
        check("t3_back_zero", result, 4'b0000);

        // 4. Most-negative operands: (-2)*(-2) = 4
        drive(1'b0, 2'b10, 2'b10);
        check("t4_ovf", {3'b000, overflow}, 4'b0000);
        tick();
        check("t4_prod4", result, 4'b0100);

        // 5. 4 + 4 wraps to -8
        check("t5_ovf_pending", {3'b000, overflow}, 4'b0001);
        tick();
        check("t5_wrap", result, 4'b1000);
        check("t5_ovf_clear", {3'b000, overflow}, 4'b0000);

        // 6. -8 + (-2) wraps to 6
        drive(1'b0, 2'b01, 2'b10);
        check("t6_ovf_pending", {3'b000, overflow}, 4'b0001);
        tick();
        check("t6_wrap", result, 4'b0110);
        check("t6_ovf_clear", {3'b000, overflow}, 4'b0000);
        tick();
        check("t6_continue", result, 4'b0100);

        // Hold with a zero operand; operand wiggle between edges must not touch result
        drive(1'b0, 2'b00, 2'b11);
        tick();
        check("hold_a0", result, 4'b0100);
        drive(1'b0, 2'b10, 2'b10);
        check("between_edges", result, 4'b0100);
        check("between_ovf", {3'b000, overflow}, 4'b0001);
        drive(1'b0, 2'b11, 2'b00);
        tick();
        check("hold_b0", result, 4'b0100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety bound so the bench always terminates.
    initial begin
        #10000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end
endmodule
